// File: rtl/grf_read_stage.sv
// grf_read_stage
//   Read-side companion of the GRF. Resolves the two D-stage source operands
//   against in-flight E/M/W writes and flags unresolved RAW hazards as a
//   stall. Resolved operands, PC and instruction are captured into the D/E
//   pipeline register.
//
//   Inputs : clk, reset (sync, active-high), D_* (decoded source info, PC,
//            instruction), GRF_RD1/2 (async file data), E/M/W write-back
//            info (WA, WE, WDValid, WD), flush.
//   Outputs: D_RD1/2 and stall (combinational), E_* (D/E register).

// Per-operand forward / hazard resolution.
module grf_fwd_lane (
  input  logic [4:0]  a,
  input  logic        use_rd,
  input  logic [31:0] rd,
  input  logic [4:0]  e_wa,
  input  logic [4:0]  m_wa,
  input  logic [4:0]  w_wa,
  input  logic        e_we,
  input  logic        m_we,
  input  logic        w_we,
  input  logic        e_rdy,
  input  logic        m_rdy,
  input  logic [31:0] e_wd,
  input  logic [31:0] m_wd,
  input  logic [31:0] w_wd,
  output logic [31:0] val,
  output logic        blocked
);
  logic hit_e, hit_m, hit_w;

  assign hit_e = e_we & (e_wa == a);
  assign hit_m = m_we & (m_wa == a);
  assign hit_w = w_we & (w_wa == a);

  // The highest-priority hit decides both data and readiness; a ready
  // lower-priority hit must not mask an unready younger producer.
  always_comb begin
    val     = rd;
    blocked = 1'b0;
    if (a == 5'd0) begin
      val = '0;
    end else if (hit_e) begin
      val     = e_wd;
      blocked = use_rd & ~e_rdy;
    end else if (hit_m) begin
      val     = m_wd;
      blocked = use_rd & ~m_rdy;
    end else if (hit_w) begin
      // File writes at the same edge we sample, so GRF data is stale here.
      val = w_wd;
    end
  end
endmodule

module grf_read_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_valid,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  input  logic        D_Use1,
  input  logic        D_Use2,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_Instr,
  input  logic [31:0] GRF_RD1,
  input  logic [31:0] GRF_RD2,
  input  logic [4:0]  E_WA,
  input  logic [4:0]  M_WA,
  input  logic [4:0]  W_WA,
  input  logic        E_WE,
  input  logic        M_WE,
  input  logic        W_WE,
  input  logic        E_WDValid,
  input  logic        M_WDValid,
  input  logic [31:0] E_WD,
  input  logic [31:0] M_WD,
  input  logic [31:0] W_WD,
  input  logic        flush,
  output logic [31:0] D_RD1,
  output logic [31:0] D_RD2,
  output logic        stall,
  output logic        E_valid,
  output logic [4:0]  E_A1,
  output logic [4:0]  E_A2,
  output logic [31:0] E_RS,
  output logic [31:0] E_RT,
  output logic [31:0] E_PC,
  output logic [31:0] E_Instr
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic        valid;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
    logic [31:0] instr;
  } de_reg_t;

  logic [NUM_OPS-1:0][4:0]  op_a;
  logic [NUM_OPS-1:0]       op_use;
  logic [NUM_OPS-1:0][31:0] op_rd;
  logic [NUM_OPS-1:0][31:0] op_val;
  logic [NUM_OPS-1:0]       op_blk;

  assign op_a   = {D_A2, D_A1};
  assign op_use = {D_Use2, D_Use1};
  assign op_rd  = {GRF_RD2, GRF_RD1};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    grf_fwd_lane u_lane (
      .a      (op_a[i]),
      .use_rd (op_use[i]),
      .rd     (op_rd[i]),
      .e_wa   (E_WA),
      .m_wa   (M_WA),
      .w_wa   (W_WA),
      .e_we   (E_WE),
      .m_we   (M_WE),
      .w_we   (W_WE),
      .e_rdy  (E_WDValid),
      .m_rdy  (M_WDValid),
      .e_wd   (E_WD),
      .m_wd   (M_WD),
      .w_wd   (W_WD),
      .val    (op_val[i]),
      .blocked(op_blk[i])
    );
  end

  assign D_RD1 = op_val[0];
  assign D_RD2 = op_val[1];
  assign stall = D_valid & (|op_blk);

  de_reg_t de_q, de_d;

  // flush outranks stall; both inject an all-zero bubble into E.
  always_comb begin
    de_d = de_q;
    if (flush || stall) begin
      de_d = '0;
    end else begin
      de_d.valid = D_valid;
      de_d.a1    = D_A1;
      de_d.a2    = D_A2;
      de_d.rs    = op_val[0];
      de_d.rt    = op_val[1];
      de_d.pc    = D_PC;
      de_d.instr = D_Instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) de_q <= '0;
    else       de_q <= de_d;
  end

  assign E_valid = de_q.valid;
  assign E_A1    = de_q.a1;
  assign E_A2    = de_q.a2;
  assign E_RS    = de_q.rs;
  assign E_RT    = de_q.rt;
  assign E_PC    = de_q.pc;
  assign E_Instr = de_q.instr;
endmodule

// File: tb/tb_grf_read_stage.sv
module tb_grf_read_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        D_valid, D_Use1, D_Use2, flush;
  logic [4:0]  D_A1, D_A2, E_WA, M_WA, W_WA;
  logic [31:0] D_PC, D_Instr, GRF_RD1, GRF_RD2, E_WD, M_WD, W_WD;
  logic        E_WE, M_WE, W_WE, E_WDValid, M_WDValid;
  logic [31:0] D_RD1, D_RD2, E_RS, E_RT, E_PC, E_Instr;
  logic        stall, E_valid;
  logic [4:0]  E_A1, E_A2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grf_read_stage dut (
    .clk(clk), .reset(reset), .D_valid(D_valid), .D_A1(D_A1), .D_A2(D_A2),
    .D_Use1(D_Use1), .D_Use2(D_Use2), .D_PC(D_PC), .D_Instr(D_Instr),
    .GRF_RD1(GRF_RD1), .GRF_RD2(GRF_RD2), .E_WA(E_WA), .M_WA(M_WA), .W_WA(W_WA),
    .E_WE(E_WE), .M_WE(M_WE), .W_WE(W_WE), .E_WDValid(E_WDValid),
    .M_WDValid(M_WDValid), .E_WD(E_WD), .M_WD(M_WD), .W_WD(W_WD), .flush(flush),
    .D_RD1(D_RD1), .D_RD2(D_RD2), .stall(stall), .E_valid(E_valid),
    .E_A1(E_A1), .E_A2(E_A2), .E_RS(E_RS), .E_RT(E_RT), .E_PC(E_PC),
    .E_Instr(E_Instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: scan producers youngest-first; first match owns the operand.
  function automatic void fwd(input logic [4:0] a, input logic use_rd,
                              input logic [31:0] rd, output logic [31:0] v,
                              output logic blk);
    logic        we[3];
    logic [4:0]  wa[3];
    logic [31:0] wd[3];
    logic        rdy[3];
    we[0] = E_WE; we[1] = M_WE; we[2] = W_WE;
    wa[0] = E_WA; wa[1] = M_WA; wa[2] = W_WA;
    wd[0] = E_WD; wd[1] = M_WD; wd[2] = W_WD;
    rdy[0] = E_WDValid; rdy[1] = M_WDValid; rdy[2] = 1'b1;
    v = rd; blk = 1'b0;
    if (a == 0) begin v = 0; return; end
    for (int i = 0; i < 3; i++)
      if (we[i] && wa[i] == a) begin
        v = wd[i]; blk = use_rd && !rdy[i]; return;
      end
  endfunction

  task automatic idle_inputs();
    reset = 0; flush = 0; D_valid = 0; D_Use1 = 0; D_Use2 = 0;
    D_A1 = 0; D_A2 = 0; D_PC = 0; D_Instr = 0; GRF_RD1 = 0; GRF_RD2 = 0;
    E_WA = 0; M_WA = 0; W_WA = 0; E_WE = 0; M_WE = 0; W_WE = 0;
    E_WDValid = 0; M_WDValid = 0; E_WD = 0; M_WD = 0; W_WD = 0;
  endtask

  task automatic rand_inputs();
    D_valid = 1'($urandom); D_Use1 = 1'($urandom); D_Use2 = 1'($urandom);
    D_A1 = 5'($urandom_range(0, 7)); D_A2 = 5'($urandom_range(0, 7));
    D_PC = $urandom; D_Instr = $urandom; GRF_RD1 = $urandom; GRF_RD2 = $urandom;
    E_WA = 5'($urandom_range(0, 7)); M_WA = 5'($urandom_range(0, 7));
    W_WA = 5'($urandom_range(0, 7));
    E_WE = 1'($urandom); M_WE = 1'($urandom); W_WE = 1'($urandom);
    E_WDValid = 1'($urandom); M_WDValid = 1'($urandom);
    E_WD = $urandom; M_WD = $urandom; W_WD = $urandom;
  endtask

  // Inputs already applied; check combinational outputs, then the E register.
  task automatic step(input string tag);
    logic [31:0] r1, r2;
    logic b1, b2, st, load;
    #2;
    fwd(D_A1, D_Use1, GRF_RD1, r1, b1);
    fwd(D_A2, D_Use2, GRF_RD2, r2, b2);
    st = D_valid && (b1 || b2);
    chk({tag, "_rd1"}, D_RD1, r1);
    chk({tag, "_rd2"}, D_RD2, r2);
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, st});
    load = !reset && !flush && !st;
    @(posedge clk); #1;
    chk({tag, "_ev"}, {31'd0, E_valid}, load ? {31'd0, D_valid} : 32'd0);
    chk({tag, "_ea1"}, {27'd0, E_A1}, load ? {27'd0, D_A1} : 32'd0);
    chk({tag, "_ea2"}, {27'd0, E_A2}, load ? {27'd0, D_A2} : 32'd0);
    chk({tag, "_ers"}, E_RS, load ? r1 : 32'd0);
    chk({tag, "_ert"}, E_RT, load ? r2 : 32'd0);
    chk({tag, "_epc"}, E_PC, load ? D_PC : 32'd0);
    chk({tag, "_eins"}, E_Instr, load ? D_Instr : 32'd0);
  endtask

  initial begin
    idle_inputs();
    @(posedge clk); #1;

    // Reset with garbage on every input.
    rand_inputs(); reset = 1; flush = 0;
    step("rst0");
    rand_inputs(); reset = 1; flush = 0;
    step("rst1");
    chk("rst_ev", {31'd0, E_valid}, 32'd0);
    chk("rst_epc", E_PC, 32'd0);
    idle_inputs();
    D_valid = 1; D_A1 = 3; D_PC = 32'h0000_3000; D_Instr = 32'h1234_5678;
    step("rst_rel");
    chk("rel_epc", E_PC, 32'h0000_3000);

    // W bypass beats stale file data.
    idle_inputs();
    D_valid = 1; D_A1 = 8; D_Use1 = 1; GRF_RD1 = 32'h1111_1111;
    W_WE = 1; W_WA = 8; W_WD = 32'hDEAD_BEEF;
    step("wbyp");
    chk("wbyp_ers", E_RS, 32'hDEAD_BEEF);

    // E > M > W priority, then register 0.
    idle_inputs();
    D_valid = 1; D_A2 = 5; D_Use2 = 1; E_WDValid = 1; M_WDValid = 1;
    E_WE = 1; M_WE = 1; W_WE = 1; E_WA = 5; M_WA = 5; W_WA = 5;
    E_WD = 32'hE; M_WD = 32'hA; W_WD = 32'hB;
    #2 chk("prio_rd2", D_RD2, 32'hE);
    step("prio");
    D_A2 = 0;
    #2 chk("r0_rd2", D_RD2, 32'd0);
    chk("r0_stall", {31'd0, stall}, 32'd0);
    step("r0");

    // Unready E hit masks a ready M hit.
    E_WDValid = 0; D_A2 = 5;
    #2 chk("mask_stall", {31'd0, stall}, 32'd1);
    step("mask");

    // Load-use: one stall cycle, then the W bypass resolves.
    idle_inputs();
    D_valid = 1; D_A1 = 9; D_Use1 = 1; M_WE = 1; M_WA = 9; M_WDValid = 0;
    D_PC = 32'h0000_3008;
    #2 chk("lu_stall", {31'd0, stall}, 32'd1);
    step("lu0");
    chk("lu_ev", {31'd0, E_valid}, 32'd0);
    M_WE = 0; W_WE = 1; W_WA = 9; W_WD = 32'h1234;
    step("lu1");
    chk("lu_ers", E_RS, 32'h1234);
    chk("lu_ev1", {31'd0, E_valid}, 32'd1);

    // Same hazard, operand not used.
    idle_inputs();
    D_valid = 1; D_A1 = 9; D_Use1 = 0; M_WE = 1; M_WA = 9; M_WDValid = 0;
    #2 chk("unused_stall", {31'd0, stall}, 32'd0);
    step("unused");

    // Flush without and with stall.
    idle_inputs();
    D_valid = 1; D_PC = 32'h0000_3004; flush = 1;
    step("fl0");
    chk("fl_epc", E_PC, 32'd0);
    D_A1 = 9; D_Use1 = 1; M_WE = 1; M_WA = 9;
    step("fl1");
    chk("fl1_ev", {31'd0, E_valid}, 32'd0);

    // Reset mid-stall.
    reset = 1; flush = 0;
    step("rst_stall");

    // Randomized sweep against the reference.
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      reset = ($urandom_range(0, 29) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
